// File: rtl/lsu_dmem_port.sv
// lsu_dmem_port: single-outstanding load/store unit driving a 64-bit data-memory bus
module lsu_dmem_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [63:0] req_wmask,
    input  logic [2:0]  req_ldtype,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [63:0] mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;
    logic [1:0]  state;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] wmask_q;
    logic        wen_q;
    logic [2:0]  ldtype_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt;
    logic        mis;
    logic [63:0] sh;
    logic [63:0] ld_val;
    logic        bus_wr;
    assign req_ready     = state == IDLE;
    assign rsp_valid     = state == RESP;
    assign mem_req_valid = state == REQ;
    assign bus_wr        = mem_req_valid && wen_q;
    assign mem_addr      = mem_req_valid ? {addr_q[63:3], 3'b000} : '0;
    assign mem_wen       = bus_wr;
    assign mem_wdata     = bus_wr ? wdata_q : '0;
    assign mem_wmask     = bus_wr ? wmask_q : '0;
    // alignment of the incoming operation; an empty store mask or the reserved load code counts as misaligned
    always_comb begin
        mis = req_wen ? (req_wmask == '0) :
              (req_ldtype == 3'b010) ? 1'b1 :
              (req_ldtype == 3'b011) ? |req_addr[2:0] :
              (req_ldtype[2:1] == 2'b00) ? |req_addr[1:0] :
              (req_ldtype[2:1] == 2'b11) ? req_addr[0] : 1'b0;
    end
    // pick the addressed field out of the bus word and extend it to 64 bits
    always_comb begin
        sh     = mem_rdata >> {addr_q[2:0], 3'b000};
        ld_val = (ldtype_q == 3'b011) ? mem_rdata :
                 (ldtype_q == 3'b001) ? {{32{sh[31]}}, sh[31:0]} :
                 (ldtype_q == 3'b000) ? {32'b0, sh[31:0]} :
                 (ldtype_q == 3'b100) ? {{56{sh[7]}}, sh[7:0]} :
                 (ldtype_q == 3'b101) ? {56'b0, sh[7:0]} :
                 (ldtype_q == 3'b110) ? {{48{sh[15]}}, sh[15:0]} :
                 {48'b0, sh[15:0]};
    end
    // operation sequencing, request capture, bus timeout and registered completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            wen_q    <= 1'b0;
            ldtype_q <= '0;
            rd_q     <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_rd   <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata;
                    wmask_q  <= req_wmask;
                    wen_q    <= req_wen;
                    ldtype_q <= req_ldtype;
                    rd_q     <= req_rd;
                    state    <= mis ? RESP : REQ;
                    if (mis) begin
                        rsp_data <= '0;
                        rsp_rd   <= req_rd;
                        rsp_err  <= 1'b1;
                    end
                end
                REQ: if (mem_req_ready) begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: if (mem_rsp_valid) begin
                    state    <= RESP;
                    rsp_data <= wen_q ? 64'd0 : ld_val;
                    rsp_rd   <= rd_q;
                    rsp_err  <= 1'b0;
                end else if (cnt == 8'd254) begin
                    state    <= RESP;
                    cnt      <= 8'd255;
                    rsp_data <= '0;
                    rsp_rd   <= rd_q;
                    rsp_err  <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_dmem_port.sv
// tb_lsu_dmem_port: randomized and directed checks of lsu_dmem_port against a behavioural model
module tb_lsu_dmem_port;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_wen;
    logic [63:0] req_addr, req_wdata, req_wmask;
    logic [2:0]  req_ldtype;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_wmask, mem_rdata;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_data;
    logic [4:0]  rsp_rd;
    int n_chk = 0;
    int n_fail = 0;
    lsu_dmem_port dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .req_ldtype(req_ldtype), .req_rd(req_rd), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic int size_of(input logic [2:0] lt);
        case (lt)
            3'b011: return 8;
            3'b001, 3'b000: return 4;
            3'b110, 3'b111: return 2;
            default: return 1;
        endcase
    endfunction
    function automatic bit misal(input logic wen, input logic [63:0] addr, input logic [63:0] wmask, input logic [2:0] lt);
        if (wen) return wmask == 64'd0;
        if (lt == 3'b010) return 1'b1;
        return (int'(addr[2:0]) % size_of(lt)) != 0;
    endfunction
    function automatic logic [63:0] load_ref(input logic [2:0] lt, input logic [63:0] addr, input logic [63:0] rdata);
        int sz;
        logic [63:0] v, keep;
        sz = size_of(lt);
        if (sz == 8) return rdata;
        v = rdata >> (8 * int'(addr[2:0]));
        keep = (64'd1 << (8 * sz)) - 64'd1;
        v = v & keep;
        if ((lt == 3'b001 || lt == 3'b100 || lt == 3'b110) && v[8 * sz - 1]) v = v | ~keep;
        return v;
    endfunction
    task automatic run_op(input logic wen, input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] wmask,
                          input logic [2:0] lt, input logic [4:0] rd, input logic [63:0] rdata,
                          input int rdly, input int sdly, input bit nors);
        bit mis, done, in_wait, saw_req;
        int rcnt, wcnt, lat, exp_lat;
        logic [63:0] exp_d;
        mis = misal(wen, addr, wmask, lt);
        done = 0; in_wait = 0; saw_req = 0; rcnt = 0; wcnt = 0; lat = 0;
        exp_d = (mis || wen || nors) ? 64'd0 : load_ref(lt, addr, rdata);
        exp_lat = mis ? 1 : (rdly + 1) + (nors ? 255 : sdly + 1) + 1;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
        req_ldtype = lt; req_rd = rd; mem_rdata = rdata;
        for (int c = 1; c <= 600 && !done; c++) begin
            @(negedge clk);
            req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
            if (rsp_valid) begin
                done = 1;
                lat = c;
            end else begin
                chk("req_ready_busy", req_ready, 0);
                if (in_wait) begin
                    chk("mem_req_valid_wait", mem_req_valid, 0);
                    mem_rsp_valid = !nors && wcnt >= sdly;
                    wcnt++;
                end else if (mem_req_valid) begin
                    saw_req = 1;
                    chk("mem_addr", mem_addr, addr & ~64'd7);
                    chk("mem_wen", mem_wen, wen);
                    chk("mem_wdata", mem_wdata, wen ? wdata : 64'd0);
                    chk("mem_wmask", mem_wmask, wen ? wmask : 64'd0);
                    mem_req_ready = rcnt >= rdly;
                    in_wait = mem_req_ready;
                    rcnt++;
                end
            end
        end
        chk("rsp_seen", done, 1);
        chk("latency", lat, exp_lat);
        chk("bus_req_issued", saw_req, !mis);
        chk("rsp_err", rsp_err, mis || nors);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_rd", rsp_rd, rd);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("req_ready_after", req_ready, 1);
        chk("rsp_data_hold", rsp_data, exp_d);
        chk("rsp_err_hold", rsp_err, mis || nors);
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wen"}, mem_wen, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wmask"}, mem_wmask, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_rd"}, rsp_rd, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
    initial begin
        logic [63:0] m;
        req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wmask = 0; req_ldtype = 0; req_rd = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run_op(0, 64'h80000003, 0, 0, 3'b100, 5'd1, 64'h00000000_F0000000, 0, 0, 0);
        run_op(0, 64'h80000004, 0, 0, 3'b000, 5'd2, 64'hDEADBEEF_12345678, 0, 0, 0);
        run_op(0, 64'h80000004, 0, 0, 3'b001, 5'd3, 64'hDEADBEEF_12345678, 0, 0, 0);
        run_op(0, 64'h80000001, 0, 0, 3'b110, 5'd4, 64'h12345678_9ABCDEF0, 0, 0, 0);
        run_op(1, 64'h80000010, 64'h0000AB00_00000000, 64'h0000FF00_00000000, 3'b011, 5'd5, 64'hFFFF, 5, 0, 0);
        run_op(0, 64'h80000008, 0, 0, 3'b011, 5'd6, 64'hCAFE, 0, 0, 1);
        run_op(0, 64'h80000008, 0, 0, 3'b011, 5'd7, 64'h01234567_89ABCDEF, 0, 0, 0);
        run_op(0, 64'h80000000, 0, 0, 3'b010, 5'd8, 64'h1, 0, 0, 0);
        run_op(1, 64'h80000000, 64'h55, 64'd0, 3'b000, 5'd9, 64'h1, 0, 0, 0);
        run_op(0, 64'h80000006, 0, 0, 3'b111, 5'd10, 64'h8001_0000_0000_0000, 1, 254, 0);
        run_op(0, 64'h80000007, 0, 0, 3'b101, 5'd11, 64'h8001_0000_0000_0000, 2, 3, 0);
        for (int i = 0; i < 40; i++) begin
            m = 0;
            if ($urandom_range(0, 4) != 0)
                for (int b = 0; b < 8; b++) if ($urandom_range(0, 1) == 1) m[8 * b +: 8] = 8'hFF;
            run_op($urandom_range(0, 2) == 0, {$urandom, $urandom}, {$urandom, $urandom}, m,
                   3'($urandom_range(0, 7)), 5'($urandom), {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end
        req_valid = 1; req_wen = 0; req_addr = 64'h10; req_ldtype = 3'b011; req_rd = 5'd9;
        @(negedge clk);
        req_valid = 0;
        chk("rst_mid_req_valid", mem_req_valid, 1);
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1;
        mem_rsp_valid = 1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_rsp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_outputs("post_rst");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
